// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch front end: opcodes, immediate
// decoders, queue entry layout and default sizes.
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 5
`endif

package inst_fetch_queue_pkg;

    localparam int IQ_WIDTH_DEFAULT  = 3;
    localparam int BHT_WIDTH_DEFAULT = 6;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } iq_entry_t;

    // J-type immediate, sign-extended to 32 bits.
    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // B-type immediate, sign-extended to 32 bits.
    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/inst_fetch_queue_bht.sv
// Table of 2-bit saturating branch counters: combinational read of the
// predicted direction, synchronous training from the commit stage.
module branch_history_table
    import inst_fetch_queue_pkg::*;
#(
    parameter int BHT_WIDTH = BHT_WIDTH_DEFAULT
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [BHT_WIDTH-1:0] rd_index,
    output logic                 rd_taken,
    input  logic                 upd_en,
    input  logic [BHT_WIDTH-1:0] upd_index,
    input  logic                 upd_taken
);

    localparam int ENTRIES = 1 << BHT_WIDTH;

    logic [1:0] counters [ENTRIES];

    // A read of the entry being trained this cycle sees the old counter.
    assign rd_taken = counters[rd_index][1];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < ENTRIES; i++) begin
                counters[i] <= 2'b01;
            end
        end else if (upd_en) begin
            if (upd_taken) begin
                if (counters[upd_index] != 2'b11) begin
                    counters[upd_index] <= counters[upd_index] + 2'd1;
                end
            end else if (counters[upd_index] != 2'b00) begin
                counters[upd_index] <= counters[upd_index] - 2'd1;
            end
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: one-outstanding-request fetch FSM, next-PC
// prediction (JAL / BHT-predicted branches) and a circular instruction queue.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int          IQ_WIDTH  = IQ_WIDTH_DEFAULT,
    parameter int          BHT_WIDTH = BHT_WIDTH_DEFAULT,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush,
    input  logic [31:0] predict_correct_pc,
    output logic        mc_en,
    output logic [31:0] mc_addr,
    input  logic        mc_rdy,
    input  logic [31:0] mc_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_predict,
    input  logic        bht_upd_en,
    input  logic [31:0] bht_upd_pc,
    input  logic        bht_upd_taken
);

    localparam int DEPTH = 1 << IQ_WIDTH;
    localparam logic [IQ_WIDTH:0] FULL_COUNT = {1'b1, {IQ_WIDTH{1'b0}}};

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]          state;
    logic [31:0]         pc;
    logic [IQ_WIDTH-1:0] head;
    logic [IQ_WIDTH-1:0] tail;
    logic [IQ_WIDTH:0]   count;
    logic [IQ_WIDTH:0]   count_next;
    iq_entry_t           queue [DEPTH];

    logic        push;
    logic        pop;
    logic        has_room_next;
    logic        bht_taken;
    logic        pred;
    logic [31:0] npc;
    logic        unused_upd_pc_bits;

    branch_history_table #(
        .BHT_WIDTH(BHT_WIDTH)
    ) u_bht (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rd_index  (pc[BHT_WIDTH+1:2]),
        .rd_taken  (bht_taken),
        .upd_en    (bht_upd_en && rdy_in),
        .upd_index (bht_upd_pc[BHT_WIDTH+1:2]),
        .upd_taken (bht_upd_taken)
    );

    assign unused_upd_pc_bits = ^{bht_upd_pc[31:BHT_WIDTH+2], bht_upd_pc[1:0]};

    // NOTE: combinational logic uses blocking '=' and assigns every output a
    // default first, so no latch is inferred; clocked state uses '<=' only.
    always_comb begin
        pred = 1'b0;
        npc  = pc + 32'd4;
        case (mc_data[6:0])
            OP_JAL: begin
                pred = 1'b1;
                npc  = pc + imm_j(mc_data);
            end
            OP_BRANCH: begin
                pred = bht_taken;
                if (bht_taken) begin
                    npc = pc + imm_b(mc_data);
                end
            end
            // The JALR target depends on a register, so fetch falls through.
            OP_JALR: npc = pc + 32'd4;
            default: npc = pc + 32'd4;
        endcase
    end

    assign out_valid     = (count != '0);
    assign out_inst      = queue[head].inst;
    assign out_pc        = queue[head].pc;
    assign out_predict   = queue[head].pred;
    assign pop           = out_valid && out_ready;
    assign push          = (state == ST_WAIT) && mc_rdy;
    assign count_next    = count + {{IQ_WIDTH{1'b0}}, push} - {{IQ_WIDTH{1'b0}}, pop};
    assign has_room_next = (count_next != FULL_COUNT);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state   <= ST_IDLE;
            pc      <= RESET_PC;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            mc_en   <= 1'b0;
            mc_addr <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                head    <= '0;
                tail    <= '0;
                count   <= '0;
                pc      <= predict_correct_pc;
                mc_en   <= 1'b1;
                mc_addr <= predict_correct_pc;
                state   <= ST_WAIT;
            end else begin
                if (pop) begin
                    head <= head + IQ_WIDTH'(1);
                end
                if (push) begin
                    tail <= tail + IQ_WIDTH'(1);
                end
                count <= count_next;
                case (state)
                    ST_IDLE: begin
                        if (count != FULL_COUNT) begin
                            mc_en   <= 1'b1;
                            mc_addr <= pc;
                            state   <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (mc_rdy) begin
                            pc <= npc;
                            // Chain the next request only if this push leaves a slot.
                            if (has_room_next) begin
                                mc_addr <= npc;
                            end else begin
                                mc_en <= 1'b0;
                                state <= ST_IDLE;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // NOTE: queue storage is deliberately not reset; validity comes solely
    // from count, which keeps the array a plain RAM.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && !flush && push) begin
            queue[tail] <= '{inst: mc_data, pc: mc_addr, pred: pred};
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench: the driver acts as memory controller and reference model,
// a negedge monitor pops expected entries on every dispatch handshake.
module tb_inst_fetch_queue;

    localparam int          IQ_WIDTH  = 2;
    localparam int          BHT_WIDTH = 6;
    localparam int          DEPTH     = 1 << IQ_WIDTH;
    localparam logic [31:0] RESET_PC  = 32'h0;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush;
    logic [31:0] predict_correct_pc;
    logic        mc_en;
    logic [31:0] mc_addr;
    logic        mc_rdy;
    logic [31:0] mc_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_predict;
    logic        bht_upd_en;
    logic [31:0] bht_upd_pc;
    logic        bht_upd_taken;

    always #5 clk_in = ~clk_in;

    inst_fetch_queue #(
        .IQ_WIDTH (IQ_WIDTH),
        .BHT_WIDTH(BHT_WIDTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .flush             (flush),
        .predict_correct_pc(predict_correct_pc),
        .mc_en             (mc_en),
        .mc_addr           (mc_addr),
        .mc_rdy            (mc_rdy),
        .mc_data           (mc_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_inst          (out_inst),
        .out_pc            (out_pc),
        .out_predict       (out_predict),
        .bht_upd_en        (bht_upd_en),
        .bht_upd_pc        (bht_upd_pc),
        .bht_upd_taken     (bht_upd_taken)
    );

    typedef enum int {K_OTHER, K_JAL, K_BRANCH, K_JALR} kind_e;
    typedef struct { logic [31:0] inst; kind_e kind; int imm; } word_t;
    typedef struct { logic [31:0] inst; logic [31:0] pc; logic pred; } exp_t;
    typedef struct { logic [31:0] pc; logic taken; } upd_t;
    typedef struct {
        logic en; logic [31:0] addr; logic valid; logic [31:0] inst; logic [31:0] pc; logic pred;
    } snap_t;

    word_t       mem [logic [31:0]];
    exp_t        sb [$];
    upd_t        upd_q [$];
    int          bht_m [1 << BHT_WIDTH];
    logic [31:0] model_pc;

    int vectors = 0;
    int miscompares = 0;

    int          ready_pct = 100, flush_pct = 0, hold_pct = 0, upd_pct = 0;
    int          cur_lat = 3, lat_cnt = 0, hold_left = 0;
    bit          rand_lat = 0, flush_req = 0, flush_on_rdy = 0;
    logic [31:0] flush_target = '0, req_addr = '0;
    bit          prev_flush = 0, prev_hold = 0, prev_idle_room = 0;
    snap_t       snap;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] enc_jal(input int imm, input logic [4:0] rd);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_branch(input int imm, input logic [2:0] f3, input logic [9:0] regs);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], regs, f3, v[4:1], v[11], 7'b1100011};
    endfunction

    function automatic int rand_off(input int bits);
        int r;
        r = int'($urandom_range(0, 19));
        if (r == 0) return -(1 << bits);
        if (r == 1) return (1 << bits) - 4;
        return (int'($urandom_range(0, 32)) - 16) * 4;
    endfunction

    function automatic word_t gen_word();
        word_t w;
        int    r;
        r = int'($urandom_range(0, 99));
        w.imm = 0;
        if (r < 12) begin
            w.kind = K_JAL;
            w.imm  = rand_off(20);
            w.inst = enc_jal(w.imm, 5'($urandom));
        end else if (r < 40) begin
            w.kind = K_BRANCH;
            w.imm  = rand_off(12);
            w.inst = enc_branch(w.imm, 3'($urandom), 10'($urandom));
        end else if (r < 45) begin
            w.kind = K_JALR;
            w.inst = $urandom;
            w.inst[14:0] = {3'b000, 5'($urandom), 7'b1100111};
        end else begin
            w.kind = K_OTHER;
            w.inst = $urandom;
            case ($urandom_range(0, 5))
                0: w.inst[6:0] = 7'b0010011;
                1: w.inst[6:0] = 7'b0110011;
                2: w.inst[6:0] = 7'b0000011;
                3: w.inst[6:0] = 7'b0100011;
                4: w.inst[6:0] = 7'b0110111;
                default: w.inst[6:0] = 7'b0010111;
            endcase
        end
        return w;
    endfunction

    function automatic word_t get_word(input logic [31:0] addr);
        if (!mem.exists(addr)) mem[addr] = gen_word();
        return mem[addr];
    endfunction

    task automatic set_word(input logic [31:0] addr, input logic [31:0] inst, input kind_e kind, input int imm);
        word_t w;
        w.inst = inst;
        w.kind = kind;
        w.imm  = imm;
        mem[addr] = w;
    endtask

    function automatic int bidx(input logic [31:0] pc);
        return int'((pc >> 2) % (1 << BHT_WIDTH));
    endfunction

    // One cycle at posedge+1: check the settled DUT state, advance the model,
    // then drive inputs for the coming edge.
    task automatic step();
        bit          do_rdy, do_flush, do_mcrdy, do_upd;
        logic [31:0] tgt, npc;
        upd_t        u;
        word_t       w;
        exp_t        e;
        int          size0;

        size0 = sb.size();
        check("out_valid", out_valid, 32'(size0 != 0));
        if (size0 == DEPTH) check("mc_en_when_full", mc_en, 0);
        if (mc_en) check("mc_addr", mc_addr, model_pc);
        if (prev_flush) check("mc_en_after_flush", mc_en, 1);
        if (prev_idle_room) check("mc_en_reissue", mc_en, 1);
        if (prev_hold) begin
            check("hold_mc_en", mc_en, snap.en);
            check("hold_mc_addr", mc_addr, snap.addr);
            check("hold_out_valid", out_valid, snap.valid);
            check("hold_out_inst", out_inst, snap.inst);
            check("hold_out_pc", out_pc, snap.pc);
            check("hold_out_predict", out_predict, snap.pred);
        end

        do_rdy = 1'b1;
        if (hold_left > 0) begin
            do_rdy = 1'b0;
            hold_left--;
        end else if (hold_pct > 0 && $urandom_range(0, 99) < hold_pct) begin
            do_rdy = 1'b0;
        end

        do_mcrdy = 1'b0;
        do_flush = 1'b0;
        tgt      = $urandom;
        if (!do_rdy) begin
            // Frozen cycles get noise on every input that must be ignored.
            do_mcrdy = hold_left[0];
            do_flush = !hold_left[0];
        end else begin
            if (!mc_en || mc_addr != req_addr) lat_cnt = 0;
            req_addr = mc_addr;
            if (mc_en) begin
                lat_cnt++;
                if (lat_cnt >= cur_lat) begin
                    do_mcrdy = 1'b1;
                    lat_cnt  = 0;
                    if (rand_lat) cur_lat = int'($urandom_range(1, 4));
                end
            end
            if (flush_req && (!flush_on_rdy || do_mcrdy)) begin
                do_flush  = 1'b1;
                tgt       = flush_target;
                flush_req = 1'b0;
            end else if (flush_pct > 0 && $urandom_range(0, 99) < flush_pct) begin
                do_flush = 1'b1;
                if ($urandom_range(0, 9) == 0) tgt = $urandom & 32'hFFFF_FFFC;
                else tgt = {22'd0, 8'($urandom), 2'b00};
            end
            if (do_flush) lat_cnt = 0;
        end

        do_upd = 1'b0;
        u.pc = $urandom;
        u.taken = 1'($urandom);
        if (do_rdy && upd_q.size() > 0) begin
            u = upd_q.pop_front();
            do_upd = 1'b1;
        end else if (!do_rdy || (upd_pct > 0 && $urandom_range(0, 99) < upd_pct)) begin
            do_upd = 1'b1;
        end

        if (do_rdy) begin
            if (do_flush) begin
                sb.delete();
                model_pc = tgt;
            end else if (do_mcrdy) begin
                w = get_word(model_pc);
                e.inst = w.inst;
                e.pc   = model_pc;
                e.pred = 1'b0;
                npc    = model_pc + 32'd4;
                if (w.kind == K_JAL) begin
                    e.pred = 1'b1;
                    npc    = model_pc + 32'(w.imm);
                end else if (w.kind == K_BRANCH) begin
                    e.pred = (bht_m[bidx(model_pc)] >= 2);
                    if (e.pred) npc = model_pc + 32'(w.imm);
                end
                sb.push_back(e);
                model_pc = npc;
            end
            if (do_upd) begin
                if (u.taken) bht_m[bidx(u.pc)] = (bht_m[bidx(u.pc)] == 3) ? 3 : bht_m[bidx(u.pc)] + 1;
                else bht_m[bidx(u.pc)] = (bht_m[bidx(u.pc)] == 0) ? 0 : bht_m[bidx(u.pc)] - 1;
            end
        end

        prev_flush     = do_rdy && do_flush;
        prev_hold      = !do_rdy;
        prev_idle_room = do_rdy && !mc_en && size0 < DEPTH;
        if (!do_rdy) snap = '{mc_en, mc_addr, out_valid, out_inst, out_pc, out_predict};

        rdy_in             = do_rdy;
        flush              = do_flush;
        predict_correct_pc = tgt;
        mc_rdy             = do_mcrdy;
        mc_data            = do_mcrdy ? get_word(mc_addr).inst : $urandom;
        out_ready          = ($urandom_range(0, 99) < ready_pct);
        bht_upd_en         = do_upd;
        bht_upd_pc         = u.pc;
        bht_upd_taken      = u.taken;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            step();
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        rdy_in = 1'b1;
        flush = 1'b0;
        predict_correct_pc = '0;
        mc_rdy = 1'b0;
        mc_data = '0;
        out_ready = 1'b0;
        bht_upd_en = 1'b0;
        bht_upd_pc = '0;
        bht_upd_taken = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        check("reset_mc_en", mc_en, 0);
        check("reset_mc_addr", mc_addr, 0);
        check("reset_out_valid", out_valid, 0);
        sb.delete();
        upd_q.delete();
        mem.delete();
        foreach (bht_m[i]) bht_m[i] = 1;
        model_pc = RESET_PC;
        lat_cnt = 0;
        req_addr = '0;
        hold_left = 0;
        flush_req = 1'b0;
        flush_on_rdy = 1'b0;
        prev_flush = 1'b0;
        prev_hold = 1'b0;
        prev_idle_room = 1'b0;
        rst_in = 1'b0;
    endtask

    always @(negedge clk_in) begin
        exp_t e;
        if (rst_in === 1'b0 && rdy_in && !flush && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("pop_without_entry", out_valid, 0);
            end else begin
                e = sb.pop_front();
                check("out_pc", out_pc, e.pc);
                check("out_inst", out_inst, e.inst);
                check("out_predict", out_predict, e.pred);
            end
        end
    end

    initial begin
        // Sequential addi stream from reset.
        do_reset();
        set_word(32'h0, 32'h0010_0093, K_OTHER, 0);
        set_word(32'h4, 32'h0010_0093, K_OTHER, 0);
        set_word(32'h8, 32'h0010_0093, K_OTHER, 0);
        ready_pct = 100;
        cur_lat = 3;
        run(30);

        // JAL chain into a BEQ, then train the BHT and refetch the branch.
        do_reset();
        set_word(32'h00, 32'h0100_006F, K_JAL, 16);
        set_word(32'h10, 32'h0100_006F, K_JAL, 16);
        set_word(32'h20, 32'h0000_0463, K_BRANCH, 8);
        run(25);
        upd_q.push_back('{32'h20, 1'b1});
        upd_q.push_back('{32'h20, 1'b1});
        run(3);
        flush_req = 1'b1;
        flush_target = 32'h20;
        run(15);
        upd_q.push_back('{32'h20, 1'b1});
        upd_q.push_back('{32'h20, 1'b1});
        run(3);
        flush_req = 1'b1;
        run(15);
        upd_q.push_back('{32'h20, 1'b0});
        run(2);
        flush_req = 1'b1;
        run(15);

        // Fill with dispatch stalled, then release a single entry.
        do_reset();
        cur_lat = 1;
        ready_pct = 0;
        run(30);
        check("full_out_valid", out_valid, 1);
        check("full_mc_en", mc_en, 0);
        ready_pct = 100;
        run(1);
        ready_pct = 0;
        run(10);
        ready_pct = 100;
        run(30);

        // Flush coinciding with returned data.
        do_reset();
        cur_lat = 3;
        run(6);
        flush_req = 1'b1;
        flush_target = 32'h100;
        flush_on_rdy = 1'b1;
        run(20);
        flush_on_rdy = 1'b0;

        // Freeze while a request is outstanding.
        for (int i = 0; i < 50 && !mc_en; i++) run(1);
        check("wait_for_mc_en", mc_en, 1);
        hold_left = 5;
        run(20);

        // Randomised traffic.
        do_reset();
        rand_lat = 1'b1;
        ready_pct = 70;
        flush_pct = 2;
        hold_pct = 5;
        upd_pct = 20;
        run(4000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Parametrised front end that fetches 32-bit RV32I instructions from the memory controller and predicts the next PC.
- Buffers fetched instructions in a circular instruction queue for the dispatch/decode stage.
- Replaces single-instruction fetch with a queue of configurable depth and a 2-bit-counter branch history table (BHT) trained by the reorder buffer.
- Flushes on ROB misprediction and redirects to the ROB-supplied correct PC.

Parameters:
IQ_WIDTH, 3, log2 of queue depth (depth = 2^IQ_WIDTH entries)
BHT_WIDTH, 6, log2 of BHT entries; index = pc[BHT_WIDTH+1:2]
RESET_PC, 32'h0, PC fetched first after reset

Ports:
clk_in  input  1  clock
rst_in  input  1  reset, synchronous, active-high
rdy_in  input  1  global ready; low freezes all state
flush  input  1  ROB misprediction flush
predict_correct_pc  input  32  redirect PC, valid when flush=1
mc_en  output  1  fetch request to memory control
mc_addr  output  32  fetch address
mc_rdy  input  1  one-cycle pulse: mc_data valid
mc_data  input  32  fetched instruction word
out_valid  output  1  queue head valid
out_ready  input  1  dispatch accepts head
out_inst  output  32  head instruction
out_pc  output  32  head instruction address
out_predict  output  1  head predicted taken (JAL: 1; branch: BHT; others: 0)
bht_upd_en  input  1  ROB commits a conditional branch
bht_upd_pc  input  32  committed branch PC
bht_upd_taken  input  1  actual outcome

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst_in is synchronous and active-high.
- Priority each edge: rst_in > rdy_in low (hold everything, ignore mc_rdy/flush/out_ready/bht_upd_en) > flush > normal.
- Reset values:
  - pc=RESET_PC; head=tail=count=0; state=IDLE; mc_en=0; mc_addr=0.
  - All BHT counters=2'b01.
  - out_valid=0; out_inst/out_pc/out_predict read the queue head, so out_inst/out_pc are don't-care while out_valid=0.
- mc_en and mc_addr are registered. The memory controller cancels a request when mc_en drops. It starts a new request the cycle after mc_rdy if mc_en stays high.
- FSM IDLE:
  - If count<2^IQ_WIDTH: mc_en<=1, mc_addr<=pc, go WAIT.
  - Else stay IDLE with mc_en=0.
- FSM WAIT:
  - Hold mc_en/mc_addr until mc_rdy.
  - On mc_rdy, push {mc_data, mc_addr, pred} at tail and set pc<=npc.
  - If the queue still has a free slot after this cycle's push/pop, issue immediately: mc_addr<=npc, stay WAIT, mc_en stays 1.
  - Otherwise mc_en<=0, go IDLE.
- At most one request outstanding; a slot is guaranteed free at issue time.
- Next-PC prediction (opcode = mc_data[6:0]):
  - JAL (1101111): npc = pc + J-imm, pred=1.
  - BRANCH (1100011): pred = BHT[idx][1]; npc = pred ? pc + B-imm : pc+4.
  - All others, including JALR: npc = pc+4, pred=0.
- Immediates are sign-extended; 32-bit add with wrap-around.
- Queue:
  - out_valid = (count!=0); pop when out_valid && out_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo 2^IQ_WIDTH.
  - Push never occurs when full (enforced by the issue rule).
- Flush (rdy_in=1):
  - head=tail=count=0 next cycle; out_valid=0 at t+1.
  - pc<=predict_correct_pc; mc_en<=1; mc_addr<=predict_correct_pc; state=WAIT.
  - An mc_rdy in the flush cycle is discarded; an out_ready pop in the flush cycle is ignored.
  - A redirect request is visible at t+1.
- BHT update on bht_upd_en: 2-bit saturating counter; increment if taken, decrement otherwise.
  - A same-cycle read of the same entry returns the pre-update value.
  - A bht_upd_en in a flush cycle is still applied.

Decomposition:
- Shared package/header holds:
  - Opcode constants OP_JAL, OP_BRANCH, OP_JALR.
  - Immediate-extraction functions imm_j, imm_b.
  - IQ_WIDTH/BHT_WIDTH defaults, alongside the existing ROB_WIDTH/REG_WIDTH macros.
- One sub-module: branch_history_table.
  - Counter array with reset init.
  - Combinational read port (index).
  - Synchronous update port (en, index, taken).
- Queue and fetch FSM stay in inst_fetch_queue.

Test Plan:
- Reset, then mc_rdy 3 cycles after each request, returning addi (0x00100093) at 0,4,8 with out_ready=1 -> mc_addr sequence 0,4,8,...; out_pc 0,4,8; out_predict=0.
- JAL x0,+16 (0x0100006F) at pc 0 -> next mc_addr=0x10; queued entry out_predict=1.
- BEQ +8 at pc 0x20 with BHT reset -> next fetch 0x24, pred=0. After two bht_upd_en taken for 0x20, refetch 0x20 -> next fetch 0x28, pred=1. Saturation holds at 2'b11 after a third update.
- Hold out_ready=0 with IQ_WIDTH=2 -> exactly 4 entries fill, then mc_en=0. A single pop re-enables mc_en next cycle, and no entry is lost or duplicated.
- Flush with predict_correct_pc=0x100 while in WAIT, with mc_rdy in the same cycle -> that data is not queued; out_valid=0 at t+1; mc_en=1, mc_addr=0x100 at t+1.
- rdy_in=0 for 5 cycles during WAIT, with mc_rdy/flush pulses -> no state change; resume identically when rdy_in=1.
